// File: rtl/spi_master.sv
// SPI master, mode 0 (SCK idles low, data sampled on SCK rise, shifted on SCK fall).
// Sends one byte MSB first per accepted tx beat and returns the byte read from MISO.
// SSEL stays low across bytes until a byte marked tx_last completes.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   tx_data/tx_valid/tx_last/tx_ready  byte input handshake
//   rx_data/rx_valid  received byte and its one-cycle strobe
//   busy              high from accept until the bus returns to idle
//   SCK/MOSI/MISO/SSEL  SPI pins
module spi_master #(
    parameter int unsigned CLK_DIV = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       SCK,
    output logic       MOSI,
    input  logic       MISO,
    output logic       SSEL
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOW,
        HIGH,
        WAIT_NEXT,
        HOLD,
        DESEL
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;       // half-period countdown, reloaded on every transition
    logic [2:0]    bit_cnt;   // falling edges completed in the current byte
    logic [6:0]    tx_shift;  // remaining bits after the one currently on MOSI
    logic          last_q;
    logic [7:0]    rx_shift;
    logic          miso_s1;
    logic          miso_s2;

    // Single sequential block: FSM, counters, shifters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            tx_shift <= '0;
            last_q   <= 1'b0;
            rx_shift <= '0;
            miso_s1  <= 1'b0;
            miso_s2  <= 1'b0;
            tx_ready <= 1'b1;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            busy     <= 1'b0;
            SCK      <= 1'b0;
            MOSI     <= 1'b0;
            SSEL     <= 1'b1;
        end else begin
            rx_valid <= 1'b0;
            miso_s1  <= MISO;
            miso_s2  <= miso_s1;
            if (cnt != '0) begin
                cnt <= cnt - CW'(1);
            end

            case (state)
                // Accept only while tx_ready is already high, so the earliest
                // accept after WAIT_NEXT entry is the following edge.
                IDLE, WAIT_NEXT: begin
                    if (tx_valid && tx_ready) begin
                        tx_shift <= tx_data[6:0];
                        last_q   <= tx_last;
                        MOSI     <= tx_data[7];
                        SSEL     <= 1'b0;
                        busy     <= 1'b1;
                        tx_ready <= 1'b0;
                        bit_cnt  <= '0;
                        cnt      <= RELOAD;
                        state    <= LOW;
                    end
                end

                // Rising edge: sample the synchronized MISO into the LSB.
                LOW: begin
                    if (cnt == '0) begin
                        SCK      <= 1'b1;
                        rx_shift <= {rx_shift[6:0], miso_s2};
                        cnt      <= RELOAD;
                        state    <= HIGH;
                    end
                end

                // Falling edge: present next bit, or finish the byte.
                HIGH: begin
                    if (cnt == '0) begin
                        SCK <= 1'b0;
                        cnt <= RELOAD;
                        if (bit_cnt == 3'd7) begin
                            MOSI     <= 1'b0;
                            rx_valid <= 1'b1;
                            rx_data  <= rx_shift;
                            if (last_q) begin
                                state <= HOLD;
                            end else begin
                                tx_ready <= 1'b1;
                                state    <= WAIT_NEXT;
                            end
                        end else begin
                            bit_cnt  <= bit_cnt + 3'd1;
                            MOSI     <= tx_shift[6];
                            tx_shift <= {tx_shift[5:0], 1'b0};
                            state    <= LOW;
                        end
                    end
                end

                // SSEL held low one half-period after the last SCK fall.
                HOLD: begin
                    if (cnt == '0) begin
                        SSEL  <= 1'b1;
                        cnt   <= RELOAD;
                        state <= DESEL;
                    end
                end

                // SSEL high one half-period before a new frame may start.
                DESEL: begin
                    if (cnt == '0) begin
                        busy     <= 1'b0;
                        tx_ready <= 1'b1;
                        state    <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter CLK_DIV, default 8: SCK half-period in clk cycles; legal range 6..255.
REQ-002 clk  input  1  sole clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 tx_data  input  8  byte to transmit, MSB first.
REQ-005 tx_valid  input  1  tx_data/tx_last valid.
REQ-006 tx_last  input  1  deassert SSEL after this byte.
REQ-007 tx_ready  output  1  byte accepted on the cycle where tx_valid && tx_ready.
REQ-008 rx_data  output  8  byte shifted in from MISO.
REQ-009 rx_valid  output  1  one-cycle strobe; rx_data valid.
REQ-010 busy  output  1  transaction in progress.
REQ-011 SCK  output  1  SPI clock, mode 0 (idle low).
REQ-012 MOSI  output  1  serial data to slave.
REQ-013 MISO  input  1  serial data from slave, asynchronous.
REQ-014 SSEL  output  1  slave select, active low.

Function
REQ-015 States SHALL be IDLE, LOW, HIGH, WAIT_NEXT, HOLD and DESEL.
REQ-016 IDLE: SSEL=1, SCK=0, MOSI=0, busy=0, tx_ready=1.
REQ-017 Accept at edge T0 (IDLE or WAIT_NEXT, tx_valid=1): latch tx_data/tx_last; from T0: SSEL=0, MOSI=tx_data[7], busy=1, tx_ready=0; enter LOW.
REQ-018 SCK rising edge k (k=1..8) SHALL occur at T0+(2k-1)*CLK_DIV; falling edge k at T0+2k*CLK_DIV.
REQ-019 MOSI SHALL update to the next bit on falling edges 1..7; after falling edge 8, MOSI=0.
REQ-020 MISO SHALL pass through a 2-flop synchronizer; the synchronized value SHALL be shifted into the rx register LSB on the clk edge at which SCK goes 1.
REQ-021 At T0+16*CLK_DIV: rx_valid=1 for exactly one cycle, rx_data = 8 sampled bits (first sampled = bit 7); rx_data holds until the next strobe.
REQ-022 Latched tx_last=0: enter WAIT_NEXT at T0+16*CLK_DIV; SSEL stays 0, SCK=0, tx_ready=1, busy=1; hold indefinitely until the next accept, which restarts REQ-017 timing with SSEL continuously low.
REQ-023 Latched tx_last=1: HOLD with SSEL=0 for CLK_DIV cycles; SSEL=1 at T0+17*CLK_DIV; DESEL with SSEL=1, busy=1, tx_ready=0 for CLK_DIV cycles; IDLE (tx_ready=1, busy=0) at T0+18*CLK_DIV.
REQ-024 tx_valid/tx_data changes while tx_ready=0 SHALL have no effect on the byte in flight.
REQ-025 Half-period counter SHALL be width ceil(log2(CLK_DIV)) and reload on every SCK transition and state change; no skew across bytes.
REQ-026 Back-to-back accept in WAIT_NEXT on the same edge as entry SHALL be impossible; the earliest accept is the edge after tx_ready rises.
REQ-027 rx_valid and accept in the same cycle SHALL both take effect.

Reset
REQ-028 rst_n=0 at any edge, including mid-byte: next state IDLE, SSEL=1, SCK=0, MOSI=0, busy=0, tx_ready=1, rx_valid=0, rx_data=0x00, synchronizer flops and counters=0; no partial rx_valid.
REQ-029 Reset release SHALL produce no SCK or SSEL glitch.

Verification
REQ-030 Loopback MISO=MOSI, CLK_DIV=8, send 0xA5 tx_last=1 -> 8 SCK pulses of 8-cycle half-period, rx_data=0xA5 strobed at T0+128, SSEL high at T0+136, tx_ready at T0+144.
REQ-031 MISO tied 1, send 0x00 -> MOSI constant 0, rx_data=0xFF.
REQ-032 Behavioural mode-0 slave returning 0x02 to 0x03: send 0x03 (tx_last=0) then 0x00 (tx_last=1) -> SSEL low across both bytes, 16 SCK pulses, second rx_data=0x02.
REQ-033 Stall tx_valid=0 for 50 cycles in WAIT_NEXT -> SSEL stays 0, SCK stays 0, busy=1, then the next byte timing restarts per REQ-018.
REQ-034 Assert rst_n=0 after SCK rising edge 4 -> SSEL=1, SCK=0 the next cycle, no rx_valid; a fresh 0x3C transfer afterwards completes correctly.
REQ-035 CLK_DIV=6, loopback 0x81 -> rx_data=0x81 at T0+96.
